// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its wait counter.
package apb_pkg;

   // Transfer phases of the APB requester.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Slave select encoding carried in the top request address bit.
   localparam logic SLV1 = 1'b0;
   localparam logic SLV2 = 1'b1;

   // The register slaves only decode the first four word addresses.
   localparam int SLV_ADDR_LIMIT = 4;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/apb_master_if.sv
// Request/response port plus the APB bus towards the two register slaves.
interface apb_master_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W:0]   req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] Paddr;
   logic              Pwrite;
   logic [DATA_W-1:0] Pwdata;
   logic              Psel1;
   logic              Psel2;
   logic              Penable;
   logic              Pready1;
   logic              Pready2;
   logic [DATA_W-1:0] Prdata1;
   logic [DATA_W-1:0] Prdata2;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output Paddr, Pwrite, Pwdata, Psel1, Psel2, Penable,
      input  Pready1, Pready2, Prdata1, Prdata2
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  Paddr, Pwrite, Pwdata, Psel1, Psel2, Penable,
      output Pready1, Pready2, Prdata1, Prdata2
   );
endinterface

// File: rtl/apb_wait_counter.sv
// Counts ACCESS cycles spent waiting on Pready; flags the last allowed cycle.
module apb_wait_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   // Count never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester for two register slaves.
module apb_master
   import apb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = 16
) (
   input  logic         Pclk,
   input  logic         Prst,
   apb_master_if.master bus
);
   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              slv_q, slv_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic              cnt_clr, cnt_en, cnt_expired;
   logic              pready_sel;
   logic [DATA_W-1:0] prdata_sel;
   logic              decode_err;

   // Only the selected slave's ready and data are ever looked at.
   assign pready_sel = (slv_q == SLV2) ? bus.Pready2 : bus.Pready1;
   assign prdata_sel = (slv_q == SLV2) ? bus.Prdata2 : bus.Prdata1;
   assign decode_err = (32'(bus.req_addr[ADDR_W-1:0]) >= SLV_ADDR_LIMIT);

   apb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
      .clk     (Pclk),
      .rst     (Prst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (cnt_expired)
   );

   // Next-state, captured request fields and the response pulse.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      slv_d        = slv_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      cnt_clr      = 1'b1;
      cnt_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr[ADDR_W-1:0];
               write_d = bus.req_write;
               wdata_d = bus.req_wdata;
               slv_d   = bus.req_addr[ADDR_W];
               if (decode_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            cnt_clr = 1'b0;
            if (pready_sel) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = write_q ? '0 : prdata_sel;
               state_d      = IDLE;
            end else if (cnt_expired) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset also abandons any transfer in flight.
   always_ff @(posedge Pclk) begin
      if (Prst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         slv_q        <= SLV1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         slv_q        <= slv_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Selects and enable are pure decodes of the phase, so only one Psel can be high.
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.Psel1      = (state_q != IDLE) && (slv_q == SLV1);
   assign bus.Psel2      = (state_q != IDLE) && (slv_q == SLV2);
   assign bus.Penable    = (state_q == ACCESS);
   assign bus.Paddr      = addr_q;
   assign bus.Pwrite     = write_q;
   assign bus.Pwdata     = wdata_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a delay-programmable slave model.
module tb_apb_master;
   logic clk = 1'b0;
   logic rst = 1'b1;

   apb_master_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   apb_master #(.DATA_W(16), .ADDR_W(3), .TIMEOUT(16)) dut (
      .Pclk (clk),
      .Prst (rst),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [15:0] rdata;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   resp_cnt = 0;

   // slave model controls
   int   dly1 = 0, dly2 = 0, acc1 = 0, acc2 = 0;
   logic force_rdy2 = 1'b0;

   // bus observation
   int   psel1_cyc = 0, psel2_cyc = 0, pen_cyc = 0;
   int   both_sel = 0, pen_bad = 0, unstable = 0;
   logic in_xfer = 1'b0;
   logic [2:0]  x_addr;
   logic [15:0] x_wdata;
   logic        x_write;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: Pready rises after a programmed number of ACCESS cycles.
   always @(negedge clk) begin
      if (bus.Psel1 === 1'b1 && bus.Penable === 1'b1) begin
         bus.Pready1 = (acc1 >= dly1);
         acc1++;
      end else begin
         acc1 = 0;
         bus.Pready1 = 1'b0;
      end
      if (force_rdy2) begin
         bus.Pready2 = 1'b1;
      end else if (bus.Psel2 === 1'b1 && bus.Penable === 1'b1) begin
         bus.Pready2 = (acc2 >= dly2);
         acc2++;
      end else begin
         acc2 = 0;
         bus.Pready2 = 1'b0;
      end
   end

   // Bus monitor: phase lengths, exclusivity and address/data stability.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.Psel1 === 1'b1) psel1_cyc++;
         if (bus.Psel2 === 1'b1) psel2_cyc++;
         if (bus.Penable === 1'b1) pen_cyc++;
         if (bus.Psel1 === 1'b1 && bus.Psel2 === 1'b1) both_sel++;
         if (bus.Penable === 1'b1 && !(bus.Psel1 === 1'b1 || bus.Psel2 === 1'b1)) pen_bad++;
         if (bus.Psel1 === 1'b1 || bus.Psel2 === 1'b1) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               x_addr  = bus.Paddr;
               x_wdata = bus.Pwdata;
               x_write = bus.Pwrite;
            end else if (bus.Paddr !== x_addr || bus.Pwdata !== x_wdata || bus.Pwrite !== x_write) begin
               unstable++;
            end
         end else begin
            in_xfer = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard on every resp_valid pulse.
   always @(negedge clk) begin
      if (bus.resp_valid === 1'b1) begin
         resp_cnt++;
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
            chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
         end
      end
   end

   task automatic clear_obs();
      psel1_cyc = 0; psel2_cyc = 0; pen_cyc = 0; unstable = 0;
   endtask

   task automatic issue(input logic wr, input logic [3:0] addr, input logic [15:0] wd);
      @(negedge clk);
      clear_obs();
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bus.req_valid = 1'b0;
   endtask

   task automatic push_exp(input logic err, input logic [15:0] rd, input int lat);
      exp_t e;
      e.err = err; e.rdata = rd; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic wait_resp(input string name);
      int start;
      start = resp_cnt;
      for (int i = 0; i < 200 && resp_cnt == start; i++) @(posedge clk);
      if (resp_cnt == start) begin
         total_cnt++;
         $display("FAIL %s_timeout: got no response expected resp_valid within 200 cycles", name);
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int rc;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.Pready1   = 1'b0;
      bus.Pready2   = 1'b0;
      bus.Prdata1   = 16'h0000;
      bus.Prdata2   = 16'h0000;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({bus.Psel1, bus.Psel2, bus.Penable, bus.Pwrite, bus.resp_valid, bus.resp_err}), 32'h0);
      chk("rst_data", 32'({bus.Paddr, bus.Pwdata, bus.resp_rdata}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(bus.req_ready), 32'h1);

      // write slave1, zero wait
      dly1 = 0; bus.Prdata1 = 16'hFFFF;
      push_exp(1'b0, 16'h0000, 2);
      issue(1'b1, 4'b0010, 16'h00A5);
      wait_resp("wr_s1");
      chk("wr_s1_psel1", 32'(psel1_cyc), 32'd2);
      chk("wr_s1_psel2", 32'(psel2_cyc), 32'd0);
      chk("wr_s1_pen", 32'(pen_cyc), 32'd1);
      chk("wr_s1_bus", 32'({x_write, x_addr, x_wdata}), 32'({1'b1, 3'd2, 16'h00A5}));

      // read slave2, two wait states
      dly2 = 2; bus.Prdata2 = 16'h1234; bus.Prdata1 = 16'h5555;
      push_exp(1'b0, 16'h1234, 4);
      issue(1'b0, 4'b1001, 16'h0000);
      wait_resp("rd_s2");
      chk("rd_s2_pen", 32'(pen_cyc), 32'd3);
      chk("rd_s2_psel2", 32'(psel2_cyc), 32'd4);
      chk("rd_s2_paddr", 32'(x_addr), 32'd1);
      chk("rd_s2_stable", 32'(unstable), 32'd0);

      // decode error
      push_exp(1'b1, 16'h0000, 0);
      issue(1'b0, 4'b1110, 16'h0000);
      wait_resp("dec_err");
      chk("dec_err_psel", 32'(psel1_cyc + psel2_cyc), 32'd0);

      // timeout on slave2
      dly2 = 1000; bus.Prdata2 = 16'hCAFE;
      push_exp(1'b1, 16'h0000, 17);
      issue(1'b0, 4'b1011, 16'h0000);
      wait_resp("tmo");
      chk("tmo_pen", 32'(pen_cyc), 32'd16);
      chk("tmo_psel2", 32'(psel2_cyc), 32'd17);

      // wrong-slave ready ignored
      dly1 = 3; force_rdy2 = 1'b1; bus.Prdata1 = 16'hBEEF; bus.Prdata2 = 16'hDEAD;
      push_exp(1'b0, 16'hBEEF, 5);
      issue(1'b0, 4'b0011, 16'h0000);
      wait_resp("wrong_rdy");
      chk("wrong_rdy_pen", 32'(pen_cyc), 32'd4);
      force_rdy2 = 1'b0;

      // reset during ACCESS
      dly1 = 1000;
      issue(1'b1, 4'b0001, 16'h7777);
      for (int i = 0; i < 20 && bus.Penable !== 1'b1; i++) @(negedge clk);
      chk("rst_mid_in_access", 32'(bus.Penable), 32'h1);
      rc = resp_cnt;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_bus", 32'({bus.Psel1, bus.Psel2, bus.Penable, bus.resp_valid}), 32'h0);
      chk("rst_mid_data", 32'({bus.Paddr, bus.Pwdata, bus.Pwrite}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
      repeat (3) @(posedge clk);
      chk("rst_mid_no_resp", 32'(resp_cnt), 32'(rc));

      chk("never_both_sel", 32'(both_sel), 32'd0);
      chk("pen_only_access", 32'(pen_bad), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Upstream APB requester for the two 16-bit register slaves (slave1, slave2).
- Accepts one transfer at a time on a simple valid/ready request port and runs the APB IDLE/SETUP/ACCESS sequence.
- Decodes the slave select and waits on the selected slave's Pready, tolerating wait states.
- Returns read data or an error on a one-cycle response pulse.

Parameters:
- DATA_W, 16, width of Pwdata/Prdata and request/response data.
- ADDR_W, 3, width of Paddr; slaves decode only Paddr < 4.
- TIMEOUT, 16, max ACCESS cycles without Pready before abort (must be >= 1).

Ports:
- Pclk  in  1  bus clock; all logic on rising edge.
- Prst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W+1  bit ADDR_W: 0 = slave1, 1 = slave2; low ADDR_W bits go to Paddr.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid with resp_valid; 0 for writes and errors.
- resp_err  out  1  valid with resp_valid; 1 = decode error or timeout.
- Paddr  out  ADDR_W  APB address.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Psel1  out  1  select slave1.
- Psel2  out  1  select slave2.
- Penable  out  1  APB enable.
- Pready1  in  1  slave1 ready.
- Pready2  in  1  slave2 ready.
- Prdata1  in  DATA_W  slave1 read data.
- Prdata2  in  DATA_W  slave2 read data.

Behaviour:
- Reset (Prst high at an edge):
  - state = IDLE.
  - Psel1, Psel2, Penable, Pwrite, resp_valid and resp_err = 0.
  - Paddr, Pwdata and resp_rdata = 0.
  - Wait counter cleared.
  - Reset mid-transfer aborts it with no response pulse; the bus drops Psel/Penable on that edge.
- req_ready = (state == IDLE); it is 1 from the first cycle after reset.
- IDLE:
  - On req_valid at an edge, register addr/write/wdata and drive Paddr/Pwrite/Pwdata.
  - Decode error (req_addr low bits >= 4): no bus activity; next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0; state stays IDLE.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - Selected Psel = 1, Penable = 0.
  - Next edge goes to ACCESS and clears the counter.
- ACCESS:
  - Psel held, Penable = 1; Paddr/Pwrite/Pwdata stable for the whole transfer.
  - At each edge, sample only the selected slave's Pready; the other Pready and Prdata are ignored.
  - Pready = 1:
    - Latch the selected Prdata into resp_rdata for reads (0 for writes).
    - Pulse resp_valid with resp_err = 0.
    - Drop Psel/Penable; return to IDLE.
  - Pready = 0: increment the counter.
  - Counter reaching TIMEOUT-1 with Pready still 0: abort, drop Psel/Penable, pulse resp_valid with resp_err = 1, resp_rdata = 0, return to IDLE.
- Latency:
  - Accept at edge N; SETUP in cycle N..N+1; first Pready sample at edge N+2.
  - Zero-wait transfer gives resp_valid high in the cycle after edge N+2.
  - Each wait state adds one cycle.
- Back-to-back: a new request is accepted on the edge that ends the resp_valid pulse (IDLE), so consecutive transfers have 1 idle bus cycle between them.
- Never assert Psel1 and Psel2 simultaneously.
- Penable is never high outside ACCESS.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - localparams SLV1 = 0 and SLV2 = 1;
  - SLV_ADDR_LIMIT = 4;
  - DATA_W and ADDR_W defaults.
- One sub-module, apb_wait_counter: counter with clear/enable inputs, TIMEOUT parameter and an expired output. Everything else stays inline.

Test Plan:
- Write slave1, req_addr = 4'b0010, wdata = 16'h00A5, Pready1 high in ACCESS -> Psel1 for 2 cycles, Penable for 1; resp_valid 3 cycles after accept; resp_err = 0; resp_rdata = 0.
- Read slave2, addr = 4'b1001, Prdata2 = 16'h1234, Pready2 delayed 2 cycles -> Penable held 3 cycles; Paddr = 1 stable throughout; resp_rdata = 16'h1234; resp_err = 0.
- Decode error, req_addr = 4'b1110 -> Psel1/Psel2 never asserted; resp_valid next cycle with resp_err = 1.
- Timeout, TIMEOUT = 16, Pready2 held 0 -> transfer aborts after 16 ACCESS cycles; resp_err = 1; Psel2 and Penable drop on the same edge.
- Wrong-slave Pready, access slave1, Pready2 = 1 and Pready1 = 0 for 3 cycles then Pready1 = 1 -> completion only on Pready1; Prdata2 ignored.
- Prst asserted during ACCESS -> next edge all bus outputs 0, no resp_valid, req_ready = 1 the cycle after Prst deasserts.
